// File: rtl/wide_add_sequencer.sv
// Wide adder/subtractor that reuses one SLICE_WIDTH-bit adder slice over
// NUM_SLICES cycles, LSB slice first, carrying between slices in a register.
module wide_add_sequencer #(
   parameter int DATA_WIDTH  = 256,
   parameter int SLICE_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   input  logic                  in_sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_sum,
   output logic                  out_carry
);

   localparam int NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
   localparam int K_W        = (NUM_SLICES > 2) ? $clog2(NUM_SLICES) : 1;
   localparam logic [K_W-1:0] LAST_K = K_W'(NUM_SLICES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_r;
   state_t                  next_state_s;
   logic                    accept_s;
   logic                    step_s;
   logic                    last_s;
   logic                    release_s;

   logic [DATA_WIDTH-1:0]   a_r;
   logic [DATA_WIDTH-1:0]   b_r;
   logic                    carry_r;
   logic [K_W-1:0]          k_r;
   logic [DATA_WIDTH-1:0]   sum_r;
   logic                    out_carry_r;
   logic                    out_valid_r;

   logic [SLICE_WIDTH-1:0]  a_slice_s;
   logic [SLICE_WIDTH-1:0]  b_slice_s;
   logic [SLICE_WIDTH:0]    slice_sum_s;

   assign in_ready  = (state_r == IDLE);
   assign out_valid = out_valid_r;
   assign out_sum   = sum_r;
   assign out_carry = out_carry_r;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode and per-cycle datapath strobes
   always_comb begin
      next_state_s = state_r;
      accept_s     = 1'b0;
      step_s       = 1'b0;
      last_s       = 1'b0;
      release_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               next_state_s = BUSY;
               accept_s     = 1'b1;
            end else begin
               next_state_s = IDLE;
            end
         end
         BUSY: begin
            step_s = 1'b1;
            if (k_r == LAST_K) begin
               next_state_s = DONE;
               last_s       = 1'b1;
            end else begin
               next_state_s = BUSY;
            end
         end
         DONE: begin
            if (out_ready) begin
               next_state_s = IDLE;
               release_s    = 1'b1;
            end else begin
               next_state_s = DONE;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Single shared slice adder; subtraction arrives as A + ~B + 1
   always_comb begin
      a_slice_s   = a_r[k_r*SLICE_WIDTH +: SLICE_WIDTH];
      b_slice_s   = b_r[k_r*SLICE_WIDTH +: SLICE_WIDTH];
      slice_sum_s = {1'b0, a_slice_s} + {1'b0, b_slice_s}
                  + {{SLICE_WIDTH{1'b0}}, carry_r};
   end

   // Operand capture, slice sequencing and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r         <= {DATA_WIDTH{1'b0}};
         b_r         <= {DATA_WIDTH{1'b0}};
         carry_r     <= 1'b0;
         k_r         <= {K_W{1'b0}};
         sum_r       <= {DATA_WIDTH{1'b0}};
         out_carry_r <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         if (accept_s) begin
            a_r     <= in_a;
            b_r     <= in_b ^ {DATA_WIDTH{in_sub}};
            carry_r <= in_sub;
            k_r     <= {K_W{1'b0}};
         end else if (step_s) begin
            sum_r[k_r*SLICE_WIDTH +: SLICE_WIDTH] <= slice_sum_s[SLICE_WIDTH-1:0];
            carry_r <= slice_sum_s[SLICE_WIDTH];
            k_r     <= k_r + K_W'(1);
            if (last_s) begin
               out_valid_r <= 1'b1;
               out_carry_r <= slice_sum_s[SLICE_WIDTH];
            end
         end else if (release_s) begin
            out_valid_r <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer: directed vectors with hand-computed
// results, backpressure, mid-operation reset and a random regression.
module tb_wide_add_sequencer;

   localparam int DW = 256;
   localparam int XW = DW + 1;

   logic          clk        = 1'b0;
   logic          rst        = 1'b1;
   logic          in_valid   = 1'b0;
   logic          in_sub     = 1'b0;
   logic [DW-1:0] in_a       = '0;
   logic [DW-1:0] in_b       = '0;
   logic          manual_rdy = 1'b1;
   logic          rnd_rdy    = 1'b1;
   logic          rand_en    = 1'b0;
   logic          out_ready;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_sum;
   logic          out_carry;

   int n_cmp    = 0;
   int n_bad    = 0;
   int cyc      = 0;
   int pushed   = 0;
   int popped   = 0;
   int last_acc = 0;
   logic [XW-1:0] exp_q[$];

   assign out_ready = rand_en ? rnd_rdy : manual_rdy;

   wide_add_sequencer #(.DATA_WIDTH(256), .SLICE_WIDTH(64)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_carry(out_carry)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every handshaken result is compared against the oldest expectation
   initial forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got %h expected none", {out_carry, out_sum});
         end else begin
            check("result", {out_carry, out_sum}, exp_q.pop_front());
            popped++;
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      rnd_rdy = ($urandom_range(0, 2) != 0);
   end

   function automatic logic [DW-1:0] rnd_word();
      logic [DW-1:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
      for (int i = 0; i < 4; i++)
         if ($urandom_range(0, 3) == 0) v[i*64 +: 64] = {64{1'b1}};
      return v;
   endfunction

   task automatic wait_idle();
      int n = 0;
      while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
      if (!in_ready) begin
         n_cmp++; n_bad++;
         $display("FAIL idle_timeout: got in_ready=0 expected 1");
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      if (!out_valid) begin
         n_cmp++; n_bad++;
         $display("FAIL valid_timeout: got out_valid=0 expected 1");
      end
   endtask

   // Issue one request; caller is always #1 after a rising edge
   task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sub,
                       input logic [XW-1:0] exp, input bit push);
      wait_idle();
      in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
      if (push) begin exp_q.push_back(exp); pushed++; end
      @(posedge clk); #1;
      last_acc = cyc;
      in_valid = 1'b0;
      in_a = ~a; in_b = rnd_word(); in_sub = ~sub;
   endtask

   initial begin
      logic [DW-1:0] a, b;
      logic          s;
      logic [XW-1:0] e;
      int            n, t0;

      #2;
      check("rst_in_ready",  XW'(in_ready),  XW'(1));
      check("rst_out_valid", XW'(out_valid), XW'(0));
      check("rst_out_sum",   XW'(out_sum),   XW'(0));
      check("rst_out_carry", XW'(out_carry), XW'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      check("release_in_ready", XW'(in_ready), XW'(1));

      // full ripple through all slices, with latency
      a = {DW{1'b1}};
      send(a, 256'd1, 1'b0, {1'b1, 256'd0}, 1'b1);
      wait_valid(n);
      check("latency", XW'(n), XW'(4));

      send(256'd7, 256'd5, 1'b1, {1'b1, 256'd2}, 1'b1);
      send(256'd5, 256'd7, 1'b1,
           {1'b0, 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE}, 1'b1);
      send(256'hFFFF_FFFF_FFFF_FFFF, 256'd1, 1'b0, {1'b0, 256'h1_0000_0000_0000_0000}, 1'b1);
      send(256'd1 << 192, 256'd1 << 192, 1'b0, {1'b0, 256'd1 << 193}, 1'b1);
      send(256'h1234_5678_9ABC_DEF0 << 100, 256'h1234_5678_9ABC_DEF0 << 100, 1'b1,
           {1'b1, 256'd0}, 1'b1);
      send(256'd0, 256'd1, 1'b1, {1'b0, {DW{1'b1}}}, 1'b1);

      // back-to-back throughput with out_ready high
      send(256'd10, 256'd20, 1'b0, {1'b0, 256'd30}, 1'b1);
      t0 = last_acc;
      send(256'd40, 256'd2, 1'b1, {1'b1, 256'd38}, 1'b1);
      check("throughput", XW'(last_acc - t0), XW'(6));

      // backpressure: DONE held, new requests refused
      wait_idle();
      manual_rdy = 1'b0;
      send(256'd100, 256'd58, 1'b1, {1'b1, 256'd42}, 1'b1);
      wait_valid(n);
      in_valid = 1'b1; in_a = 256'd9; in_b = 256'd9; in_sub = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp_out_valid", XW'(out_valid), XW'(1));
         check("bp_outputs",   {out_carry, out_sum}, {1'b1, 256'd42});
         check("bp_in_ready",  XW'(in_ready), XW'(0));
      end
      in_valid = 1'b0;
      manual_rdy = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", XW'(out_valid), XW'(0));
      check("bp_release_ready", XW'(in_ready), XW'(1));
      @(posedge clk); #1;
      check("bp_no_stray_accept", XW'(in_ready), XW'(1));

      // reset in the middle of BUSY at k = 2
      send({DW{1'b1}}, {DW{1'b1}}, 1'b0, '0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", XW'(out_valid), XW'(0));
      check("midrst_out_sum",   XW'(out_sum),   XW'(0));
      check("midrst_out_carry", XW'(out_carry), XW'(0));
      check("midrst_in_ready",  XW'(in_ready),  XW'(1));
      @(posedge clk); #1;
      rst = 1'b0;
      check("postrst_in_ready", XW'(in_ready), XW'(1));
      send(256'd3, 256'd4, 1'b0, {1'b0, 256'd7}, 1'b1);

      // random regression with random consumer gaps
      rand_en = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         a = rnd_word();
         b = ($urandom_range(0, 9) == 0) ? a : rnd_word();
         s = $urandom_range(0, 1);
         if (s) e = {(a >= b) ? 1'b1 : 1'b0, a - b};
         else   e = {1'b0, a} + {1'b0, b};
         send(a, b, s, e, 1'b1);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      n = 0;
      while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
      check("drain_empty", XW'(exp_q.size()), XW'(0));
      check("result_count", XW'(popped), XW'(pushed));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
